multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multicycle FSM that sequences the RV32I single-datapath core through FETCH/DECODE/EXEC/MEM/WB. It works alongside the per-opcode control decoder: the decoder supplies the static datapath selects, and this block supplies the timed strobes. These strobes are IR load, PC write, register-file write and data-memory read/write. It handles the ready-handshakes to instruction and data memory, with timeout and illegal-opcode trapping.

Parameters:
TIMEOUT, 15, max cycles to wait for imem_ready/dmem_ready before trapping (1..255)
RETIRE_W, 32, width of retired-instruction counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
run  in  1  level; 1 = keep issuing instructions
opcode  in  7  instr[6:0] from IR
funct3  in  3  instr[14:12] from IR
branch_taken  in  1  branch comparator result, valid in EXEC
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
imem_req  out  1  instruction fetch request
ir_load  out  1  load IR from imem
pc_we  out  1  PC write strobe
pc_sel  out  2  0=pc+4, 1=jal target, 2=branch target, 3=jalr target
reg_we  out  1  register-file write strobe
dmem_re  out  1  data read request
dmem_we  out  1  data write request
state  out  3  current state (debug)
trap  out  1  sticky trap flag
trap_cause  out  2  0=none, 1=illegal, 2=imem timeout, 3=dmem timeout
retire_count  out  RETIRE_W  instructions retired, wraps modulo 2^RETIRE_W

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: state=IDLE; all strobes 0; pc_sel=0; trap=0; trap_cause=0; retire_count=0; wait counter=0.
- Output timing: state, trap, trap_cause and counters are registered. Strobes are combinational from state and inputs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE:
  - run=1 -> FETCH.
  - All strobes 0.
- FETCH:
  - imem_req=1.
  - imem_ready=1: ir_load=1, -> DECODE.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT without ready -> TRAP, cause 2.
- DECODE (1 cycle):
  - Classify as R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR or LUI/AUIPC.
  - Legal funct3 values: LOAD/STORE 010, JALR 000, BRANCH 000/001/100/101. All others, and unknown opcodes -> TRAP, cause 1.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - BRANCH: pc_we=1, pc_sel=2 if branch_taken else 0; retire; -> next.
  - LOAD/STORE -> MEM.
  - All other classes -> WB.
- MEM:
  - LOAD holds dmem_re=1; STORE holds dmem_we=1, until dmem_ready.
  - Ready with LOAD -> WB.
  - Ready with STORE: pc_we=1, pc_sel=0; retire; -> next.
  - Wait counter as in FETCH; timeout -> TRAP, cause 3, and the strobe drops the same edge.
- WB (1 cycle):
  - reg_we=1 and pc_we=1.
  - pc_sel: 1 for JAL, 3 for JALR, else 0.
  - Retire; -> next.
- "next": FETCH if run=1, else IDLE. run is sampled only at instruction boundaries; deasserting run mid-instruction completes the instruction.
- TRAP:
  - All strobes 0; trap=1; trap_cause frozen.
  - Exit only by reset.
- Wait counter: cleared on every state entry; 8 bits wide. Ready arriving in the same cycle the count reaches TIMEOUT counts as success.
- Retire: retire_count increments by 1 in any cycle where pc_we=1; wraps to 0. Exactly one pc_we per legal instruction.
- Mutual exclusion: reg_we, dmem_re and dmem_we are never asserted together; imem_req never coincides with dmem_re/dmem_we.
- Reset mid-operation: the same edge returns to IDLE, all strobes go 0 next cycle, trap clears, and counters clear.
- Cycle counts with ready in the first cycle:
  - ALU/JAL/JALR/LUI/AUIPC: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 1101111, 0110111, 0010111);
  - state encoding;
  - pc_sel codes;
  - trap_cause codes;
  - instruction-class enum.
- Sub-module opcode_classifier (combinational): opcode and funct3 in; class and legal out.

Test Plan:
- add (opcode 0110011, funct3 000), run=1, ready immediate -> imem_req cycle 1, ir_load cycle 1, reg_we+pc_we (pc_sel=0) cycle 4, retire_count=1.
- lw (0000011/010), dmem_ready delayed 3 cycles -> dmem_re held 4 cycles, then WB reg_we; total 8 cycles; no overlap of reg_we/dmem_re.
- beq with branch_taken=1, then branch_taken=0 -> pc_we in EXEC with pc_sel=2, then pc_sel=0; each 3 cycles; retire_count=2.
- jalr (1100111/000) -> WB pc_sel=3, reg_we=1; opcode 1111111 -> TRAP, trap_cause=1, all strobes stay 0 for 20 cycles; reset clears trap.
- TIMEOUT=15, imem_ready held 0 -> TRAP on 15th waiting cycle, cause 2; sw with dmem_ready held 0 -> cause 3, dmem_we drops.
- run deasserted during a load's MEM -> instruction completes, then IDLE. Reset asserted in MEM -> next cycle IDLE, dmem_re=0, retire_count=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multicycle control path: opcodes, sequencer
// state encoding, pc_sel and trap-cause codes, and the instruction classes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcIAlu   = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StWb     = 3'd5;
  localparam logic [2:0] StTrap   = 3'd6;

  localparam logic [1:0] PcPlus4  = 2'd0;
  localparam logic [1:0] PcJal    = 2'd1;
  localparam logic [1:0] PcBranch = 2'd2;
  localparam logic [1:0] PcJalr   = 2'd3;

  localparam logic [1:0] CauseNone        = 2'd0;
  localparam logic [1:0] CauseIllegal     = 2'd1;
  localparam logic [1:0] CauseImemTimeout = 2'd2;
  localparam logic [1:0] CauseDmemTimeout = 2'd3;

  typedef enum logic [2:0] {
    ClsR,
    ClsIAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsUpper
  } instr_class_e;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control/handshake bundle between the multicycle sequencer (master) and the
// datapath plus memories (slave).
interface multicycle_sequencer_if #(
  parameter int unsigned RETIRE_W = 32
);
  logic                run;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                branch_taken;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                ir_load;
  logic                pc_we;
  logic [1:0]          pc_sel;
  logic                reg_we;
  logic                dmem_re;
  logic                dmem_we;
  logic [2:0]          state;
  logic                trap;
  logic [1:0]          trap_cause;
  logic [RETIRE_W-1:0] retire_count;

  modport master (
    input  run, opcode, funct3, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_load, pc_we, pc_sel, reg_we, dmem_re, dmem_we,
    output state, trap, trap_cause, retire_count
  );

  modport slave (
    output run, opcode, funct3, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_load, pc_we, pc_sel, reg_we, dmem_re, dmem_we,
    input  state, trap, trap_cause, retire_count
  );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational RV32I opcode classifier: maps opcode/funct3 to an instruction
// class and flags encodings the sequencer must trap on.
module opcode_classifier
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output instr_class_e cls,
  output logic         legal
);

  always_comb begin
    cls   = ClsR;
    legal = 1'b0;
    case (opcode)
      OpcR:      begin cls = ClsR;      legal = 1'b1;                end
      OpcIAlu:   begin cls = ClsIAlu;   legal = 1'b1;                end
      OpcLoad:   begin cls = ClsLoad;   legal = (funct3 == 3'b010);  end
      OpcStore:  begin cls = ClsStore;  legal = (funct3 == 3'b010);  end
      // beq/bne/blt/bge are exactly the funct3 codes with bit 1 clear
      OpcBranch: begin cls = ClsBranch; legal = ~funct3[1];          end
      OpcJal:    begin cls = ClsJal;    legal = 1'b1;                end
      OpcJalr:   begin cls = ClsJalr;   legal = (funct3 == 3'b000);  end
      OpcLui,
      OpcAuipc:  begin cls = ClsUpper;  legal = 1'b1;                end
      default:   begin cls = ClsR;      legal = 1'b0;                end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I multicycle core: timed
// strobes, memory ready handshakes with timeout, and sticky trap reporting.
module multicycle_sequencer
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 15,
  parameter int unsigned RETIRE_W = 32
) (
  input logic                    clock,
  input logic                    reset,
  multicycle_sequencer_if.master bus
);

  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  logic [2:0]          state_q, state_d;
  logic [7:0]          wait_q, wait_d;
  instr_class_e        cls_q, cls_d, dec_cls;
  logic                dec_legal;
  logic                trap_q, trap_d;
  logic [1:0]          cause_q, cause_d;
  logic [RETIRE_W-1:0] retire_q, retire_d;
  logic                imem_req, ir_load, pc_we, reg_we, dmem_re, dmem_we;
  logic [1:0]          pc_sel;
  logic                wait_expired;
  logic [2:0]          boundary_state;

  opcode_classifier u_classifier (
    .opcode (bus.opcode),
    .funct3 (bus.funct3),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  assign wait_expired   = (wait_q == WaitLast);
  // run only matters where one instruction ends and the next would begin
  assign boundary_state = bus.run ? StFetch : StIdle;

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    wait_d   = 8'd0;
    cause_d  = cause_q;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = PcPlus4;
    reg_we   = 1'b0;
    dmem_re  = 1'b0;
    dmem_we  = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end else if (wait_expired) begin
          state_d = StTrap;
          cause_d = CauseImemTimeout;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: begin
        cls_d = dec_cls;
        if (dec_legal) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end
      end
      StExec: begin
        case (cls_q)
          ClsBranch: begin
            pc_we   = 1'b1;
            pc_sel  = bus.branch_taken ? PcBranch : PcPlus4;
            state_d = boundary_state;
          end
          ClsLoad, ClsStore: state_d = StMem;
          default:           state_d = StWb;
        endcase
      end
      StMem: begin
        dmem_re = (cls_q == ClsLoad);
        dmem_we = (cls_q == ClsStore);
        if (bus.dmem_ready) begin
          if (cls_q == ClsStore) begin
            pc_we   = 1'b1;
            state_d = boundary_state;
          end else begin
            state_d = StWb;
          end
        end else if (wait_expired) begin
          state_d = StTrap;
          cause_d = CauseDmemTimeout;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        pc_sel  = (cls_q == ClsJal)  ? PcJal  :
                  (cls_q == ClsJalr) ? PcJalr : PcPlus4;
        state_d = boundary_state;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    trap_d   = trap_q | (state_d == StTrap);
    retire_d = retire_q + {{(RETIRE_W-1){1'b0}}, pc_we};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      wait_q   <= 8'd0;
      cls_q    <= ClsR;
      trap_q   <= 1'b0;
      cause_q  <= CauseNone;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      cls_q    <= cls_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      retire_q <= retire_d;
    end
  end

  assign bus.imem_req     = imem_req;
  assign bus.ir_load      = ir_load;
  assign bus.pc_we        = pc_we;
  assign bus.pc_sel       = pc_sel;
  assign bus.reg_we       = reg_we;
  assign bus.dmem_re      = dmem_re;
  assign bus.dmem_we      = dmem_we;
  assign bus.state        = state_q;
  assign bus.trap         = trap_q;
  assign bus.trap_cause   = cause_q;
  assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction expected cycle traces built
// from the instruction-timing rules, directed corner cases and random programs.
module tb_multicycle_sequencer;

  localparam int unsigned TimeoutCycles = 15;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLd    = 7'b0000011;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpSt    = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpBad   = 7'b1111111;

  localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDecode = 3'd2, SExec = 3'd3;
  localparam logic [2:0] SMem  = 3'd4, SWb    = 3'd5, STrap   = 3'd6;

  typedef struct {
    logic        run;
    logic        imem_ready;
    logic        dmem_ready;
    logic        branch_taken;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [10:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicycle_sequencer_if #(.RETIRE_W(32)) bus ();

  multicycle_sequencer #(
    .TIMEOUT  (TimeoutCycles),
    .RETIRE_W (32)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          total = 0;
  int          bad   = 0;
  vec_t        trace[$];
  logic        at_idle;
  logic [31:0] exp_retire;

  function automatic logic [10:0] ex(input logic req, input logic ld, input logic we,
                                     input logic [1:0] sel, input logic rwe, input logic re,
                                     input logic dwe, input logic [2:0] st);
    return {req, ld, we, sel, rwe, re, dwe, st};
  endfunction

  function automatic vec_t mk(input logic run, input logic ir, input logic dr, input logic bt,
                              input logic [6:0] opc, input logic [2:0] f3,
                              input logic [10:0] e);
    vec_t v;
    v.run = run; v.imem_ready = ir; v.dmem_ready = dr; v.branch_taken = bt;
    v.opcode = opc; v.funct3 = f3; v.exp = e;
    return v;
  endfunction

  function automatic logic [10:0] observed();
    return {bus.imem_req, bus.ir_load, bus.pc_we, bus.pc_sel, bus.reg_we,
            bus.dmem_re, bus.dmem_we, bus.state};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    bus.run          = v.run;
    bus.imem_ready   = v.imem_ready;
    bus.dmem_ready   = v.dmem_ready;
    bus.branch_taken = v.branch_taken;
    bus.opcode       = v.opcode;
    bus.funct3       = v.funct3;
    #1;
    check(name, 32'(observed()), 32'(v.exp));
    @(posedge clock);
    #1;
  endtask

  task automatic play(input string name);
    int n;
    n = 0;
    while (trace.size() > 0) begin
      apply(trace.pop_front(), $sformatf("%s cyc%0d {req,ld,pcwe,sel,rwe,re,we,st}", name, n));
      n++;
    end
  endtask

  task automatic check_status(input string name, input logic trap, input logic [1:0] cause);
    check({name, " retire_count"}, bus.retire_count, exp_retire);
    check({name, " trap"}, 32'(bus.trap), 32'(trap));
    check({name, " trap_cause"}, 32'(bus.trap_cause), 32'(cause));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.run = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    bus.branch_taken = 1'b0; bus.opcode = 7'd0; bus.funct3 = 3'd0;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    exp_retire = 32'd0;
    at_idle = 1'b1;
  endtask

  // Optional IDLE launch cycle, fetch wait cycles, the fetch itself and decode.
  task automatic add_prefix(input logic [6:0] opc, input logic [2:0] f3, input int idly,
                            input logic rm);
    if (at_idle) trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, opc, f3, ex(0, 0, 0, 0, 0, 0, 0, SIdle)));
    for (int i = 0; i < idly; i++)
      trace.push_back(mk(rm, 1'b0, 1'($urandom), 1'b0, opc, f3, ex(1, 0, 0, 0, 0, 0, 0, SFetch)));
    trace.push_back(mk(rm, 1'b1, 1'b0, 1'b0, opc, f3, ex(1, 1, 0, 0, 0, 0, 0, SFetch)));
    trace.push_back(mk(rm, 1'($urandom), 1'($urandom), 1'b0, opc, f3,
                       ex(0, 0, 0, 0, 0, 0, 0, SDecode)));
    at_idle = 1'b0;
  endtask

  // rm drives run inside the instruction (ignored), re is run at its last cycle.
  task automatic add_instr(input logic [6:0] opc, input logic [2:0] f3, input logic bt,
                           input int idly, input int ddly, input logic rm, input logic re);
    logic ld, st;
    logic [1:0] wb_sel;
    ld = (opc == OpLd);
    st = (opc == OpSt);
    wb_sel = (opc == OpJal) ? 2'd1 : ((opc == OpJalr) ? 2'd3 : 2'd0);
    add_prefix(opc, f3, idly, rm);
    if (opc == OpBr) begin
      trace.push_back(mk(re, 1'b0, 1'b0, bt, opc, f3,
                         ex(0, 0, 1, bt ? 2'd2 : 2'd0, 0, 0, 0, SExec)));
    end else begin
      trace.push_back(mk(rm, 1'b0, 1'b0, bt, opc, f3, ex(0, 0, 0, 0, 0, 0, 0, SExec)));
      if (ld || st) begin
        for (int j = 0; j < ddly; j++)
          trace.push_back(mk(rm, 1'($urandom), 1'b0, 1'b0, opc, f3,
                             ex(0, 0, 0, 0, 0, ld, st, SMem)));
        if (st) trace.push_back(mk(re, 1'b0, 1'b1, 1'b0, opc, f3, ex(0, 0, 1, 0, 0, 0, 1, SMem)));
        else    trace.push_back(mk(rm, 1'b0, 1'b1, 1'b0, opc, f3, ex(0, 0, 0, 0, 0, 1, 0, SMem)));
      end
      if (!st) trace.push_back(mk(re, 1'b0, 1'b0, 1'b0, opc, f3, ex(0, 0, 1, wb_sel, 1, 0, 0, SWb)));
    end
    at_idle = !re;
  endtask

  task automatic rand_instr(output logic [6:0] opc, output logic [2:0] f3);
    f3 = 3'($urandom);
    case ($urandom_range(0, 8))
      0: opc = OpR;
      1: opc = OpI;
      2: begin opc = OpLd;   f3 = 3'b010; end
      3: begin opc = OpSt;   f3 = 3'b010; end
      4: begin opc = OpBr;   f3[1] = 1'b0; end
      5: opc = OpJal;
      6: begin opc = OpJalr; f3 = 3'b000; end
      7: opc = OpLui;
      default: opc = OpAuipc;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[6];
    logic [6:0] bad_opc[5];
    logic [2:0] bad_f3[5];
    logic [6:0] opc;
    logic [2:0] f3;
    logic       bt, re;
    int         idly, ddly;

    do_reset();
    check("reset strobes/state", 32'(observed()), 32'(ex(0, 0, 0, 0, 0, 0, 0, SIdle)));
    check_status("reset", 1'b0, 2'd0);

    // add from IDLE, ready at once, run dropped in WB
    tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, OpR, 3'b000, ex(0, 0, 0, 0, 0, 0, 0, SIdle));
    tbl[1] = mk(1'b1, 1'b1, 1'b0, 1'b0, OpR, 3'b000, ex(1, 1, 0, 0, 0, 0, 0, SFetch));
    tbl[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, OpR, 3'b000, ex(0, 0, 0, 0, 0, 0, 0, SDecode));
    tbl[3] = mk(1'b1, 1'b0, 1'b1, 1'b1, OpR, 3'b000, ex(0, 0, 0, 0, 0, 0, 0, SExec));
    tbl[4] = mk(1'b0, 1'b0, 1'b0, 1'b0, OpR, 3'b000, ex(0, 0, 1, 0, 1, 0, 0, SWb));
    tbl[5] = mk(1'b0, 1'b1, 1'b0, 1'b0, OpR, 3'b000, ex(0, 0, 0, 0, 0, 0, 0, SIdle));
    for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("add table row%0d", i));
    exp_retire = 32'd1;
    check_status("add", 1'b0, 2'd0);
    at_idle = 1'b1;

    add_instr(OpLd, 3'b010, 1'b0, 0, 3, 1'b1, 1'b1);
    play("lw dmem delay 3");
    exp_retire += 1;
    check_status("lw", 1'b0, 2'd0);

    add_instr(OpBr, 3'b000, 1'b1, 0, 0, 1'b1, 1'b1);
    add_instr(OpBr, 3'b001, 1'b0, 0, 0, 1'b1, 1'b1);
    play("beq taken then not");
    exp_retire += 2;
    check_status("beq pair", 1'b0, 2'd0);

    add_instr(OpJalr, 3'b000, 1'b0, 0, 0, 1'b1, 1'b1);
    add_instr(OpJal, 3'b111, 1'b0, 0, 0, 1'b1, 1'b1);
    add_instr(OpSt, 3'b010, 1'b0, 0, 0, 1'b1, 1'b1);
    add_instr(OpSt, 3'b010, 1'b0, 0, 2, 1'b1, 1'b1);
    add_instr(OpLui, 3'b000, 1'b0, 0, 0, 1'b1, 1'b1);
    play("jalr jal sw sw lui");
    exp_retire += 5;
    check_status("jalr..lui", 1'b0, 2'd0);

    // ready on the last allowed wait cycle still succeeds
    add_instr(OpI, 3'b101, 1'b0, TimeoutCycles - 1, 0, 1'b1, 1'b1);
    add_instr(OpLd, 3'b010, 1'b0, 0, TimeoutCycles - 1, 1'b1, 1'b1);
    play("ready at timeout boundary");
    exp_retire += 2;
    check_status("boundary", 1'b0, 2'd0);

    // run dropped before/while the load is in MEM: it completes, then IDLE
    add_instr(OpLd, 3'b010, 1'b0, 0, 2, 1'b0, 1'b0);
    trace.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, OpLd, 3'b010, ex(0, 0, 0, 0, 0, 0, 0, SIdle)));
    trace.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, OpLd, 3'b010, ex(0, 0, 0, 0, 0, 0, 0, SIdle)));
    play("run drop in lw");
    exp_retire += 1;
    check_status("run drop", 1'b0, 2'd0);
    at_idle = 1'b1;

    add_prefix(OpBad, 3'b000, 0, 1'b1);
    repeat (20) trace.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, OpBad, 3'b000,
                                   ex(0, 0, 0, 0, 0, 0, 0, STrap)));
    play("illegal opcode");
    check_status("illegal opcode", 1'b1, 2'd1);
    do_reset();
    check("post-trap reset strobes/state", 32'(observed()), 32'(ex(0, 0, 0, 0, 0, 0, 0, SIdle)));
    check_status("post-trap reset", 1'b0, 2'd0);

    bad_opc = '{OpLd, OpSt, OpBr, OpJalr, 7'b0000000};
    bad_f3  = '{3'b000, 3'b011, 3'b010, 3'b001, 3'b000};
    for (int k = 0; k < 5; k++) begin
      add_prefix(bad_opc[k], bad_f3[k], 0, 1'b1);
      repeat (2) trace.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, bad_opc[k], bad_f3[k],
                                    ex(0, 0, 0, 0, 0, 0, 0, STrap)));
      play($sformatf("illegal funct3 case%0d", k));
      check_status($sformatf("illegal funct3 case%0d", k), 1'b1, 2'd1);
      do_reset();
    end

    trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, OpR, 3'b000, ex(0, 0, 0, 0, 0, 0, 0, SIdle)));
    repeat (TimeoutCycles) trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, OpR, 3'b000,
                                              ex(1, 0, 0, 0, 0, 0, 0, SFetch)));
    repeat (2) trace.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, OpR, 3'b000,
                                  ex(0, 0, 0, 0, 0, 0, 0, STrap)));
    play("imem timeout");
    check_status("imem timeout", 1'b1, 2'd2);
    do_reset();

    add_prefix(OpSt, 3'b010, 0, 1'b1);
    trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, OpSt, 3'b010, ex(0, 0, 0, 0, 0, 0, 0, SExec)));
    repeat (TimeoutCycles) trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, OpSt, 3'b010,
                                              ex(0, 0, 0, 0, 0, 0, 1, SMem)));
    repeat (2) trace.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, OpSt, 3'b010,
                                  ex(0, 0, 0, 0, 0, 0, 0, STrap)));
    play("dmem timeout");
    check_status("dmem timeout", 1'b1, 2'd3);
    do_reset();

    // reset while a load waits in MEM
    add_instr(OpR, 3'b000, 1'b0, 0, 0, 1'b1, 1'b1);
    add_prefix(OpLd, 3'b010, 0, 1'b1);
    trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, OpLd, 3'b010, ex(0, 0, 0, 0, 0, 0, 0, SExec)));
    repeat (3) trace.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, OpLd, 3'b010,
                                  ex(0, 0, 0, 0, 0, 1, 0, SMem)));
    play("lw before reset");
    exp_retire = 32'd1;
    check_status("before mid reset", 1'b0, 2'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reset in MEM strobes/state", 32'(observed()), 32'(ex(0, 0, 0, 0, 0, 0, 0, SIdle)));
    exp_retire = 32'd0;
    check_status("reset in MEM", 1'b0, 2'd0);
    reset = 1'b0;
    at_idle = 1'b1;

    repeat (200) begin
      rand_instr(opc, f3);
      bt   = 1'($urandom);
      idly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TimeoutCycles - 1)) : 0;
      ddly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TimeoutCycles - 1)) : 0;
      re   = ($urandom_range(0, 4) != 0);
      add_instr(opc, f3, bt, idly, ddly, 1'($urandom), re);
      play($sformatf("rand op%07b f3%03b", opc, f3));
      exp_retire += 1;
      check_status("rand", 1'b0, 2'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
